// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared widths and FSM encoding for the hazard/stall unit
package hazard_stall_unit_pkg;

  localparam int DEF_REG_ADDRESS_LEN = 4;
  localparam int DEF_CNT_W           = 16;

  // Scoreboard slot order, oldest writer last
  localparam int SB_EXE = 0;
  localparam int SB_MEM = 1;
  localparam int SB_WB  = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_stall_unit_sb_hit.sv
// rtl/hazard_stall_unit_sb_hit.sv - single scoreboard entry vs ID source comparator
module sb_hit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDRESS_LEN = DEF_REG_ADDRESS_LEN
) (
  input  logic                       valid,
  input  logic                       wb_en,
  input  logic [REG_ADDRESS_LEN-1:0] dst,
  input  logic [REG_ADDRESS_LEN-1:0] src1,
  input  logic                       src1_used,
  input  logic [REG_ADDRESS_LEN-1:0] src2,
  input  logic                       src2_used,
  output logic                       hit
);

  assign hit = valid & wb_en &
               ((src1_used & (dst == src1)) | (src2_used & (dst == src2)));

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - hazard detector, stall/flush/freeze control and stall statistics
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDRESS_LEN = DEF_REG_ADDRESS_LEN,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_forwarding,
  input  logic                       id_valid,
  input  logic [REG_ADDRESS_LEN-1:0] id_src1,
  input  logic [REG_ADDRESS_LEN-1:0] id_src2,
  input  logic                       id_src1_used,
  input  logic                       id_src2_used,
  input  logic                       id_wb_en,
  input  logic [REG_ADDRESS_LEN-1:0] id_dst,
  input  logic                       id_mem_r_en,
  input  logic                       branch_taken,
  input  logic                       mem_wait,
  output logic                       hazard_stall,
  output logic                       id_bubble,
  output logic                       flush,
  output logic                       pipe_freeze,
  output logic [1:0]                 state,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           stall_events
);

  logic [2:0]                 sb_valid;
  logic [2:0]                 sb_wb_en;
  logic [2:0]                 sb_load;
  logic [REG_ADDRESS_LEN-1:0] sb_dst [3];

  logic       hit_exe, hit_mem;
  logic       raw, stall_int, flush_int;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] cyc_q, evt_q;

  sb_hit #(.REG_ADDRESS_LEN(REG_ADDRESS_LEN)) u_hit_exe (
    .valid(sb_valid[SB_EXE]), .wb_en(sb_wb_en[SB_EXE]), .dst(sb_dst[SB_EXE]),
    .src1(id_src1), .src1_used(id_src1_used),
    .src2(id_src2), .src2_used(id_src2_used),
    .hit(hit_exe)
  );

  sb_hit #(.REG_ADDRESS_LEN(REG_ADDRESS_LEN)) u_hit_mem (
    .valid(sb_valid[SB_MEM]), .wb_en(sb_wb_en[SB_MEM]), .dst(sb_dst[SB_MEM]),
    .src1(id_src1), .src1_used(id_src1_used),
    .src2(id_src2), .src2_used(id_src2_used),
    .hit(hit_mem)
  );

  // With forwarding only a load still in EXE cannot be bypassed in time
  assign raw       = id_valid & (en_forwarding ? (hit_exe & sb_load[SB_EXE])
                                               : (hit_exe | hit_mem));
  assign stall_int = raw & ~mem_wait & ~branch_taken;
  assign flush_int = branch_taken & ~mem_wait;

  assign pipe_freeze  = ~rst & mem_wait;
  assign flush        = ~rst & flush_int;
  assign hazard_stall = ~rst & stall_int;
  assign id_bubble    = ~rst & stall_int;
  assign state        = rst ? 2'b00 : state_q;
  assign stall_cycles = rst ? '0 : cyc_q;
  assign stall_events = rst ? '0 : evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid <= '0;
      sb_wb_en <= '0;
      sb_load  <= '0;
      for (int i = 0; i < 3; i++) sb_dst[i] <= '0;
    end else if (!mem_wait) begin
      sb_valid[SB_WB]  <= sb_valid[SB_MEM];
      sb_wb_en[SB_WB]  <= sb_wb_en[SB_MEM];
      sb_load[SB_WB]   <= sb_load[SB_MEM];
      sb_dst[SB_WB]    <= sb_dst[SB_MEM];
      sb_valid[SB_MEM] <= sb_valid[SB_EXE];
      sb_wb_en[SB_MEM] <= sb_wb_en[SB_EXE];
      sb_load[SB_MEM]  <= sb_load[SB_EXE];
      sb_dst[SB_MEM]   <= sb_dst[SB_EXE];
      // A stalled or flushed ID instruction leaves a bubble behind it
      sb_valid[SB_EXE] <= id_valid & ~stall_int & ~flush_int;
      sb_wb_en[SB_EXE] <= id_wb_en;
      sb_load[SB_EXE]  <= id_mem_r_en;
      sb_dst[SB_EXE]   <= id_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RUN;
    if (mem_wait)       state_d = ST_WAIT;
    else if (stall_int) state_d = ST_STALL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      evt_q <= '0;
    end else if (stall_int) begin
      if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (state_q == ST_RUN && evt_q != '1) evt_q <= evt_q + 1'b1;
    end
  end

endmodule
